// File: rtl/tm1638_pkg.sv
// tm1638_pkg: command bytes, FSM encoding and key decode
// shared by the TM1638 key reader and display writer.
package tm1638_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    WAIT,
    READ
  } tm_state_e;

  localparam logic [7:0] CMD_READ_KEYS = 8'h42;

  localparam int KEY_LO_BIT = 0;
  localparam int KEY_HI_BIT = 4;

  function automatic logic [7:0] decode_keys(
    input logic [31:0] kb
  );
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i]   = kb[8*i+KEY_LO_BIT];
      k[i+4] = kb[8*i+KEY_HI_BIT];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// tm1638_bit_timer: low-then-high serial bit cells with
// fall/rise strobes one cycle before each tm_clk edge.
module tm1638_bit_timer #(
  parameter int HALF_PERIOD = 4,
  parameter int CW = $clog2(HALF_PERIOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          fall,
  output logic          rise,
  output logic          phase,
  output logic [CW-1:0] cnt
);

  logic last;

  assign last = cnt == CW'(HALF_PERIOD - 1);
  assign fall = en && phase && last;
  assign rise = en && !phase && last;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues the 0x42 read-keys command and
// shifts in the 32-bit key scan from the TM1638.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int WAIT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dio_in,
  output logic        tm_clk,
  output logic        tm_stb,
  output logic        dio_out,
  output logic        dio_oe,
  output logic        busy,
  output logic        valid,
  output logic [31:0] key_bytes,
  output logic [7:0]  keys
);

  localparam int DLY_MAX =
    (HALF_PERIOD > WAIT_CYCLES) ? HALF_PERIOD : WAIT_CYCLES;
  localparam int DW = $clog2(DLY_MAX + 1);
  localparam int CW = $clog2(HALF_PERIOD);

  tm_state_e state, state_n;

  logic [DW-1:0] dly;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;
  logic          tmr_en;
  logic          fall;
  logic          rise;
  logic          phase;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_cnt_unused;
  logic          dly_hp;
  logic          dly_wait;

  tm1638_bit_timer #(
    .HALF_PERIOD(HALF_PERIOD),
    .CW         (CW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tmr_en),
    .fall (fall),
    .rise (rise),
    .phase(phase),
    .cnt  (tmr_cnt)
  );

  assign tmr_cnt_unused = ^tmr_cnt;

  assign dly_hp   = dly == DW'(HALF_PERIOD - 1);
  assign dly_wait = dly == DW'(WAIT_CYCLES - 1);

  assign busy   = state != IDLE;
  assign tm_stb = state == IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A start coinciding with valid is dropped on purpose
  always_comb begin
    state_n = state;
    tmr_en  = 1'b0;
    tm_clk  = 1'b1;
    dio_oe  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !valid) state_n = SETUP;
      end
      SETUP: begin
        dio_oe = 1'b1;
        if (dly_hp) state_n = CMD;
      end
      CMD: begin
        tmr_en = 1'b1;
        tm_clk = phase;
        dio_oe = 1'b1;
        if (fall && bit_cnt == 5'd7) state_n = WAIT;
      end
      WAIT: begin
        if (dly_wait) state_n = READ;
      end
      READ: begin
        tmr_en = 1'b1;
        tm_clk = phase;
        if (fall && bit_cnt == 5'd31) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dio_out   <= 1'b1;
      valid     <= 1'b0;
      key_bytes <= '0;
      keys      <= '0;
    end else begin
      valid <= 1'b0;
      if ((state == SETUP || state == WAIT) && state_n == state)
        dly <= dly + 1'b1;
      else
        dly <= '0;
      if (state_n != state) bit_cnt <= '0;
      else if (fall)        bit_cnt <= bit_cnt + 1'b1;
      // dio_out moves with the falling edge of tm_clk
      if (state == IDLE && state_n == SETUP)
        dio_out <= CMD_READ_KEYS[0];
      else if (state == CMD && fall && state_n == CMD)
        dio_out <= CMD_READ_KEYS[bit_cnt[2:0] + 3'd1];
      else if (state_n == IDLE)
        dio_out <= 1'b1;
      if (state == READ && rise)
        shreg <= {dio_in, shreg[31:1]};
      if (state == READ && state_n == IDLE) begin
        valid     <= 1'b1;
        key_bytes <= shreg;
        keys      <= decode_keys(shreg);
      end
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader: TM1638 bus model with a scoreboard
// of expected scan results and protocol monitors.
module tb_tm1638_key_reader;

  localparam int HP   = 4;
  localparam int WC   = 8;
  localparam int LAT  = 1 + 81 * HP + WC;
  localparam int LAT2 = 1 + 81 * 2 + 1;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        dio_in = 1'b0;
  logic        tm_clk, tm_stb, dio_out, dio_oe, busy, valid;
  logic [31:0] key_bytes;
  logic [7:0]  keys;

  logic        start2  = 1'b0;
  logic        dio_in2 = 1'b1;
  logic        tm_clk2, tm_stb2, dio_out2, dio_oe2, busy2, valid2;
  logic [31:0] key_bytes2;
  logic [7:0]  keys2;

  always #5 clk = ~clk;

  tm1638_key_reader u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dio_in   (dio_in),
    .tm_clk   (tm_clk),
    .tm_stb   (tm_stb),
    .dio_out  (dio_out),
    .dio_oe   (dio_oe),
    .busy     (busy),
    .valid    (valid),
    .key_bytes(key_bytes),
    .keys     (keys)
  );

  tm1638_key_reader #(
    .HALF_PERIOD(2),
    .WAIT_CYCLES(1)
  ) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .dio_in   (dio_in2),
    .tm_clk   (tm_clk2),
    .tm_stb   (tm_stb2),
    .dio_out  (dio_out2),
    .dio_oe   (dio_oe2),
    .busy     (busy2),
    .valid    (valid2),
    .key_bytes(key_bytes2),
    .keys     (keys2)
  );

  typedef struct {
    int          t;
    logic [31:0] kb;
    logic [7:0]  k;
  } exp_t;

  exp_t        sbq[$];
  int          cyc       = 0;
  int          n_chk     = 0;
  int          n_fail    = 0;
  logic [31:0] cur_data  = '0;
  logic [31:0] held_kb   = '0;
  logic [7:0]  held_k    = '0;
  logic [7:0]  cmd_ref   = 8'h42;
  int          cmd_idx   = 0;
  int          rd_idx    = 0;
  int          last_fall = 0;
  logic        prev_clk  = 1'b1;
  logic        prev_oe   = 1'b0;
  logic        prev_dout = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] ref_keys(input logic [31:0] d);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]   = d[8*i];
      k[i+4] = d[8*i+4];
    end
    return k;
  endfunction

  // TM1638 model and monitor
  always @(negedge clk) begin
    exp_t e;
    logic fell;
    if (!rst_n) begin
      sbq.delete();
      held_kb = '0;
      held_k  = '0;
      cmd_idx = 0;
      rd_idx  = 0;
    end else begin
      fell = prev_clk && !tm_clk;
      chk("busy_vs_stb", busy, !tm_stb);
      if (fell && !tm_stb && cmd_idx < 8) begin
        chk("cmd_oe", dio_oe, 1'b1);
        chk($sformatf("cmd_bit%0d", cmd_idx), dio_out,
            cmd_ref[cmd_idx]);
        cmd_idx++;
      end else if (fell && !tm_stb) begin
        dio_in = (rd_idx < 32) ? cur_data[rd_idx] : 1'b0;
        if (rd_idx > 0) chk("read_cell", cyc - last_fall, 2 * HP);
        last_fall = cyc;
        rd_idx++;
      end
      if (dio_oe && prev_oe && !fell)
        chk("dout_stable", dio_out, prev_dout);
      if (!tm_stb && rd_idx > 0) chk("read_oe", dio_oe, 1'b0);
      if (valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_valid: actual 1 required 0 (cycle %0d)",
                   cyc);
        end else begin
          e = sbq.pop_front();
          chk("valid_cycle", cyc, e.t);
          chk("key_bytes", key_bytes, e.kb);
          chk("keys", keys, e.k);
          chk("read_bits", rd_idx, 32);
          chk("cmd_bits", cmd_idx, 8);
        end
        held_kb = key_bytes;
        held_k  = keys;
        cmd_idx = 0;
        rd_idx  = 0;
      end else if (tm_stb) begin
        chk("idle_clk", tm_clk, 1'b1);
        chk("idle_oe", dio_oe, 1'b0);
        chk("idle_dout", dio_out, 1'b1);
        chk("hold_kb", key_bytes, held_kb);
        chk("hold_keys", keys, held_k);
      end
    end
    prev_clk  = tm_clk;
    prev_oe   = dio_oe;
    prev_dout = dio_out;
  end

  task automatic issue(input logic [31:0] d);
    exp_t e;
    cur_data = d;
    e.t  = cyc + LAT;
    e.kb = d;
    e.k  = ref_keys(d);
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 50 && !seen; i++) begin
      @(negedge clk);
      seen = valid;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL valid_timeout: actual no valid required valid");
    end
  endtask

  task automatic scan(input logic [31:0] d);
    issue(d);
    wait_valid();
    @(negedge clk);
  endtask

  initial begin
    int   t0;
    int   nf;
    int   lf;
    bit   seen;
    logic p2;
    repeat (3) @(negedge clk);
    chk("rst_stb", tm_stb, 1'b1);
    chk("rst_clk", tm_clk, 1'b1);
    chk("rst_oe", dio_oe, 1'b0);
    chk("rst_dout", dio_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_kb", key_bytes, 32'h0);
    chk("rst_keys", keys, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    scan(32'h0000_0000);
    scan(32'h0010_0001);
    chk("keys_0x41", keys, 8'h41);
    scan(32'h1111_1111);
    chk("keys_0xff", keys, 8'hff);
    for (int i = 0; i < 6; i++) scan($urandom());

    // restart while busy
    issue($urandom());
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();

    // start in the valid cycle is dropped, next cycle taken
    start = 1'b1;
    @(negedge clk);
    chk("restart_ignored", busy, 1'b0);
    issue(32'hffff_ffff);
    wait_valid();
    @(negedge clk);

    // reset mid-scan
    issue($urandom());
    repeat (149) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_stb", tm_stb, 1'b1);
    chk("abort_clk", tm_clk, 1'b1);
    chk("abort_oe", dio_oe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", valid, 1'b0);
    chk("abort_keys", keys, 8'h0);
    chk("abort_kb", key_bytes, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 20) @(negedge clk);

    // short-timing instance
    t0 = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen = 1'b0;
    nf = 0;
    lf = 0;
    p2 = 1'b1;
    for (int i = 0; i < LAT2 + 40 && !seen; i++) begin
      @(negedge clk);
      if (p2 && !tm_clk2 && !tm_stb2 && !dio_oe2) begin
        if (nf > 0) chk("cell2", cyc - lf, 4);
        lf = cyc;
        nf++;
      end
      p2 = tm_clk2;
      if (valid2) begin
        seen = 1'b1;
        chk("valid2_cycle", cyc, t0 + LAT2);
        chk("key_bytes2", key_bytes2, 32'hffff_ffff);
        chk("keys2", keys2, 8'hff);
        chk("reads2", nf, 32);
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL valid2_timeout: actual no valid required valid");
    end

    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_key_reader.md
TM1638_KEY_READER -- requirements
Module: tm1638_key_reader

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: system-clock cycles per tm_clk half period, minimum 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 8: system-clock cycles between the last command bit and the first read bit, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: key-scan request pulse.
REQ-006 SHALL have port dio_in, input, 1 bit: DIO pad input from the TM1638.
REQ-007 SHALL have port tm_clk, output, 1 bit: TM1638 CLK line.
REQ-008 SHALL have port tm_stb, output, 1 bit: TM1638 STB line.
REQ-009 SHALL have port dio_out, output, 1 bit: DIO drive value.
REQ-010 SHALL have port dio_oe, output, 1 bit: DIO drive enable; 0 releases the pad.
REQ-011 SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-012 SHALL have port valid, output, 1 bit: single-cycle pulse when scan results update.
REQ-013 SHALL have port key_bytes, output, 32 bits: raw scan bytes; byte0 = bits 7:0.
REQ-014 SHALL have port keys, output, 8 bits: decoded key state; 1 = pressed.

Function
REQ-015 SHALL implement an FSM with states IDLE, SETUP, CMD, WAIT, READ.
REQ-016 SHALL accept start only in IDLE; start is ignored while busy=1.
REQ-017 Start accepted at cycle 0 SHALL give tm_stb=0, busy=1 and state SETUP from cycle 1.
REQ-018 SETUP SHALL last HALF_PERIOD cycles with tm_clk=1, dio_oe=1 and dio_out = command bit 0.
REQ-019 CMD SHALL shift out the command 0x42 LSB first as 8 bits.
REQ-020 Each CMD bit SHALL be HALF_PERIOD cycles of tm_clk=0 followed by HALF_PERIOD cycles of tm_clk=1.
REQ-021 dio_out SHALL change only on the tm_clk falling edge.
REQ-022 WAIT SHALL hold tm_clk=1 and dio_oe=0 for WAIT_CYCLES cycles.
REQ-023 READ SHALL clock 32 bits with the same low/high timing as CMD, keeping dio_oe=0.
REQ-024 In READ, dio_in SHALL be sampled on the cycle tm_clk goes 0->1 and shifted in LSB first; first bit = key_bytes[0].
REQ-025 After the 32nd bit's high phase, in the same cycle: tm_stb=1, busy=0, valid=1, key_bytes and keys updated, return to IDLE.
REQ-026 With default parameters, valid SHALL occur at cycle 1+81*HALF_PERIOD+WAIT_CYCLES = 333.
REQ-027 Decode SHALL be keys[i] = key_bytes[8*i+0] and keys[i+4] = key_bytes[8*i+4], for i=0..3.
REQ-028 key_bytes and keys SHALL hold their values between scans.
REQ-029 A start in the cycle valid is asserted SHALL be ignored; the earliest accepted restart is the following cycle.
REQ-030 In IDLE: tm_clk=1, tm_stb=1, dio_oe=0, dio_out=1.

Reset
REQ-031 rst_n=0 at any clock edge, including mid-transaction, SHALL force IDLE, tm_clk=1, tm_stb=1, dio_oe=0, dio_out=1, busy=0, valid=0, key_bytes=0, keys=0.
REQ-032 A transaction aborted by reset SHALL NOT assert valid or update key outputs.

Structure
REQ-033 Command byte 0x42, FSM state encoding and the key-decode bit positions SHALL live in shared package tm1638_pkg, also used by the display writer.
REQ-034 Bit timing SHALL be a sub-module tm1638_bit_timer producing fall/rise strobes and a half-period counter, reusable by the display writer.

Verification
REQ-035 Defaults, start pulse, TM1638 model returns 0x00000000 -> dio_out bits 0,1,0,0,0,0,1,0 on falling edges; valid at cycle 333; keys=0x00.
REQ-036 Model returns bytes 0x01,0x00,0x10,0x00 -> key_bytes=0x00100001; keys=0x41.
REQ-037 Model returns 0x11111111 -> keys=0xFF; dio_oe=0 for every READ cycle.
REQ-038 Second start at cycle 100 of a scan -> ignored; exactly one valid; busy continuous.
REQ-039 rst_n low at cycle 150 -> next edge: tm_stb=1, tm_clk=1, dio_oe=0, busy=0; no valid; keys=0.
REQ-040 HALF_PERIOD=2, WAIT_CYCLES=1 -> valid at cycle 164; bit cells measured as 4 clk cycles.
